// File: rtl/serial_add_pkg.sv
// Shared types and constants for the bit-serial adder sequencer.
package serial_add_pkg;

   localparam int DEF_WIDTH = 8;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Start/busy/done handshake and operand/result bus of serial_add_ctrl.
// The sub request line exists only when SERIAL_SUB_EN is defined.
interface serial_add_ctrl_if
   import serial_add_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) ();

   logic             start;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
`ifdef SERIAL_SUB_EN
   logic             sub;
`endif
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
   logic             carry_out;
   logic             overflow;

   modport master (
      output start, op_a, op_b,
`ifdef SERIAL_SUB_EN
      output sub,
`endif
      input  busy, done, result, carry_out, overflow
   );

   modport slave (
      input  start, op_a, op_b,
`ifdef SERIAL_SUB_EN
      input  sub,
`endif
      output busy, done, result, carry_out, overflow
   );

endinterface

// File: rtl/serial_fa_cell.sv
// 1-bit full adder with its registered carry. load seeds the carry at the
// start of an operation; en advances it once per processed bit.
module serial_fa_cell (
   input  logic clk,
   input  logic reset,
   input  logic en,
   input  logic load,
   input  logic carry_init,
   input  logic a,
   input  logic b,
   output logic sum,
   output logic carry_in_q,
   output logic carry_next
);

   assign sum        = a ^ b ^ carry_in_q;
   assign carry_next = (a & b) | (a & carry_in_q) | (b & carry_in_q);

   // carry register: seed on load, advance on each serial step
   always_ff @(posedge clk) begin
      if (reset)     carry_in_q <= 1'b0;
      else if (load) carry_in_q <= carry_init;
      else if (en)   carry_in_q <= carry_next;
   end

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: captures two operands on start, feeds them
// LSB-first through serial_fa_cell and reports result, carry and overflow.
// Optional subtract mode (A-B) is enabled with the SERIAL_SUB_EN macro.
module serial_add_ctrl
   import serial_add_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic              clk,
   input  logic              reset,
   serial_add_ctrl_if.slave  bus
);

   localparam int            CW   = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t           state, state_nx;
   logic             accept, step, last;
   logic [WIDTH-1:0] a_sr, b_sr, res_sr, result_q;
   logic [CW-1:0]    cnt;
   logic             co_q, ov_q;
   logic             sub_q, cin_init;
   logic             b_bit, sum, c_in, c_nx;

`ifdef SERIAL_SUB_EN
   assign cin_init = bus.sub;

   // subtract mode flag, fixed for the whole operation
   always_ff @(posedge clk) begin
      if (reset)       sub_q <= 1'b0;
      else if (accept) sub_q <= bus.sub;
   end
`else
   assign cin_init = 1'b0;
   assign sub_q    = 1'b0;
`endif

   // subtract = add the inverted B bits with a carry-in of 1
   assign b_bit = b_sr[0] ^ sub_q;

   serial_fa_cell u_cell (
      .clk        (clk),
      .reset      (reset),
      .en         (step),
      .load       (accept),
      .carry_init (cin_init),
      .a          (a_sr[0]),
      .b          (b_bit),
      .sum        (sum),
      .carry_in_q (c_in),
      .carry_next (c_nx)
   );

   // state register
   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nx;
   end

   // next state and datapath strobes; start is honoured in IDLE and DONE
   always_comb begin
      state_nx = state;
      accept   = 1'b0;
      step     = 1'b0;
      last     = 1'b0;
      case (state)
         S_IDLE, S_DONE: begin
            if (bus.start) begin
               accept   = 1'b1;
               state_nx = S_RUN;
            end else begin
               state_nx = S_IDLE;
            end
         end
         S_RUN: begin
            step = 1'b1;
            if (cnt == LAST) begin
               last     = 1'b1;
               state_nx = S_DONE;
            end
         end
         default: state_nx = S_IDLE;
      endcase
   end

   // operand/sum shifting; visible outputs only update on the MSB step so
   // they hold the previous answer for the whole of the next operation
   always_ff @(posedge clk) begin
      if (reset) begin
         a_sr     <= '0;
         b_sr     <= '0;
         res_sr   <= '0;
         result_q <= '0;
         cnt      <= '0;
         co_q     <= 1'b0;
         ov_q     <= 1'b0;
      end else if (accept) begin
         a_sr <= bus.op_a;
         b_sr <= bus.op_b;
         cnt  <= '0;
      end else if (step) begin
         a_sr   <= a_sr >> 1;
         b_sr   <= b_sr >> 1;
         res_sr <= {sum, res_sr[WIDTH-1:1]};
         cnt    <= cnt + 1'b1;
         if (last) begin
            result_q <= {sum, res_sr[WIDTH-1:1]};
            co_q     <= c_nx;
            ov_q     <= c_in ^ c_nx;
         end
      end
   end

   assign bus.busy      = (state == S_RUN);
   assign bus.done      = (state == S_DONE);
   assign bus.result    = result_q;
   assign bus.carry_out = co_q;
   assign bus.overflow  = ov_q;

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
Sequencer for a bit-serial adder datapath. Accepts two parallel WIDTH-bit operands on a start pulse and feeds them LSB-first, one bit per cycle, into a 1-bit full-adder cell with a registered carry. It shifts the sum bits into a result register and reports unsigned carry and signed overflow. It sits between the register file/ALU-select logic and the serial adder cell, with a start/busy/done handshake.

Parameters:
WIDTH, 8, operand and result width in bits (legal range 2..32).

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request; sampled only when state is IDLE or DONE
op_a  input  WIDTH  operand A, captured on accepted start
op_b  input  WIDTH  operand B, captured on accepted start
sub  input  1  present only with SERIAL_SUB_EN; 1 = compute A-B, captured on accepted start
busy  output  1  high while state is RUN
done  output  1  one-cycle pulse; result, carry_out and overflow are valid
result  output  WIDTH  sum, registered, held until the next accepted start
carry_out  output  1  carry out of the MSB (no-borrow flag when subtracting)
overflow  output  1  signed overflow: carry into MSB XOR carry out of MSB

Behaviour:
- Reset (synchronous, regardless of state): state=IDLE; busy=0, done=0, result=0, carry_out=0, overflow=0; bit counter=0; carry register=0; operand shift registers=0.
- FSM states and transitions:
  - IDLE: start=1 captures op_a, op_b (and sub) into shift registers, clears the counter and loads the carry-in (0 for add) -> RUN. Otherwise stay in IDLE.
  - RUN: each cycle the cell adds a[0]+b[0]+carry. The sum bit enters the result shift register at the MSB and shifts right. The operand registers shift right, the carry register updates, and the counter increments. When counter==WIDTH-1, the last bit completes -> DONE.
  - DONE: done=1 for exactly this cycle. carry_out and overflow are registered from the MSB step. start=1 here is accepted as in IDLE (-> RUN, back-to-back). Otherwise -> IDLE.
- Latency: start sampled at edge T; bit i is processed in cycle T+1+i; done is high in cycle T+WIDTH+1. Maximum throughput is one operation per WIDTH+1 cycles.
- start during RUN is ignored; operand input changes during RUN have no effect.
- result, carry_out and overflow keep their last values through IDLE. They are overwritten at the end of the next operation, not cleared on start.
- overflow uses the carry into bit WIDTH-1, latched at counter==WIDTH-1, XOR the final carry.
- Wrap-around: sums modulo 2^WIDTH; no saturation.
- Reset asserted mid-RUN aborts the operation: no done pulse, and all outputs go to their reset values on that edge.
- Reset and start asserted in the same cycle: reset wins.

Optional Feature:
SERIAL_SUB_EN
- Defined: the sub port exists. When sub=1 is captured, op_b bits are inverted as they shift out and the carry register initialises to 1, giving A-B. carry_out=1 means no borrow.
- Undefined: no sub port, add only, carry initialises to 0.

Decomposition:
- Package serial_add_pkg: state encoding constants S_IDLE=2'd0, S_RUN=2'd1, S_DONE=2'd2; default WIDTH constant.
- Sub-module serial_fa_cell: combinational 1-bit full adder plus the carry flip-flop.
  - Ports: clk, reset, en, load, carry_init, a, b, sum, carry_in_q, carry_next.
  - The controller instantiates one serial_fa_cell and owns the FSM, counter and shift registers.

Test Plan:
- WIDTH=8, start with A=0x7F, B=0x01 at cycle T -> busy T+1..T+8; done only at T+9; result=0x80, carry_out=0, overflow=1.
- A=0xFF, B=0x01 -> result=0x00, carry_out=1, overflow=0. Then A=0x00, B=0x00 -> result=0x00, carry_out=0, overflow=0.
- With SERIAL_SUB_EN:
  - A=0x05, B=0x07, sub=1 -> result=0xFE, carry_out=0, overflow=0.
  - A=0x80, B=0x01, sub=1 -> result=0x7F, carry_out=1, overflow=1.
- Start pulsed again at T+3 during RUN with different operands -> ignored; first result 0x80 still delivered at T+9. Start asserted in the DONE cycle (T+9) with A=0x10, B=0x20 -> busy from T+10, done at T+18, result=0x30.
- Reset asserted at T+4 mid-RUN -> next cycle: busy=0, done=0, result=0, flags=0, no done pulse. A following start with A=0x03, B=0x04 -> result=0x07 after WIDTH+1 cycles.
- Reset and start high in the same cycle in IDLE -> remains IDLE; busy stays 0.
